sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 26 ++
 rtl/sram_arbiter.sv | 102 ++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester/SRAM bus bundle for the two-port SRAM arbiter.
// slave = arbiter view, master = requesters + SRAM pad model view.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  i_cs0, i_cs1;
  logic                  i_we0, i_we1;
  logic [ADDR_WIDTH-1:0] i_addr0, i_addr1;
  logic [7:0]            i_wdata0, i_wdata1;
  logic                  o_ack0, o_ack1;
  logic [7:0]            o_rdata;
  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic [7:0]            o_sram_wdata;
  logic [7:0]            i_sram_rdata;
  logic                  o_sram_cs, o_sram_we, o_sram_oe;

  modport slave (
    input  i_cs0, i_cs1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_sram_rdata,
    output o_ack0, o_ack1, o_rdata, o_sram_addr, o_sram_wdata, o_sram_cs, o_sram_we, o_sram_oe
  );

  modport master (
    output i_cs0, i_cs1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_sram_rdata,
    input  o_ack0, o_ack1, o_rdata, o_sram_addr, o_sram_wdata, o_sram_cs, o_sram_we, o_sram_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an async SRAM: IDLE -> ACCESS (WAIT_CYCLES+1) -> DONE.
// Define SRAM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to port 0.
module sram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic           i_clk,
  input logic           i_reset_n,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef struct packed {
    logic                  port;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  req_t       r_req, w_win;
  logic [7:0] r_rdata, r_sram_wdata, w_wdata;
  logic       w_any, w_grant1;
  logic       w_cs, w_we, w_oe, w_ack0, w_ack1;

  assign w_any = bus.i_cs0 | bus.i_cs1;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  logic r_last;
  // On a tie, port 1 wins only if port 0 had the previous grant.
  assign w_grant1 = bus.i_cs1 & (~bus.i_cs0 | ~r_last);

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n)                    r_last <= 1'b1;
    else if (r_state == IDLE && w_any) r_last <= w_grant1;
`else
  assign w_grant1 = bus.i_cs1 & ~bus.i_cs0;
`endif

  always_comb begin
    w_win.port = w_grant1;
    w_win.we   = w_grant1 ? bus.i_we1   : bus.i_we0;
    w_win.addr = w_grant1 ? bus.i_addr1 : bus.i_addr0;
    w_wdata    = w_grant1 ? bus.i_wdata1 : bus.i_wdata0;
  end

  always_comb begin
    w_next = r_state;
    w_cs   = 1'b0;
    w_we   = 1'b0;
    w_oe   = 1'b0;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    case (r_state)
      IDLE:   if (w_any) w_next = ACCESS;
      ACCESS: begin
        w_cs = 1'b1;
        w_we = r_req.we;
        w_oe = ~r_req.we;
        if (r_cnt == 4'd0) w_next = DONE;
      end
      DONE: begin
        w_ack0 = ~r_req.port;
        w_ack1 = r_req.port;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req        <= '0;
      r_rdata      <= 8'd0;
      r_sram_wdata <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_any) begin
          r_cnt <= 4'(WAIT_CYCLES);
          r_req <= w_win;
          if (w_win.we) r_sram_wdata <= w_wdata;
        end
        ACCESS: begin
          if (r_cnt != 4'd0)  r_cnt   <= r_cnt - 4'd1;
          else if (!r_req.we) r_rdata <= bus.i_sram_rdata;
        end
        default: ;
      endcase
    end

  // Address and write data are latch-held, so they keep their last value outside ACCESS.
  assign bus.o_sram_addr  = r_req.addr;
  assign bus.o_sram_wdata = r_sram_wdata;
  assign bus.o_rdata      = r_rdata;
  assign bus.o_sram_cs    = w_cs;
  assign bus.o_sram_we    = w_we;
  assign bus.o_sram_oe    = w_oe;
  assign bus.o_ack0       = w_ack0;
  assign bus.o_ack1       = w_ack1;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences and a randomized
// run checked against a transaction-level timing/memory model.
module tb_sram_arbiter;
  localparam int AW  = 16;
  localparam int W_A = 2;
  localparam int W_B = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(AW)) bus_a ();
  sram_arbiter_if #(.ADDR_WIDTH(AW)) bus_b ();

  sram_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W_A)) u_a (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_a));
  sram_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W_B)) u_b (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_b));

  // Behavioural SRAMs (low 8 address bits), with an optional read-data override on A.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  always @(posedge clk) if (bus_a.o_sram_cs && bus_a.o_sram_we) mem_a[bus_a.o_sram_addr[7:0]] <= bus_a.o_sram_wdata;
  always @(posedge clk) if (bus_b.o_sram_cs && bus_b.o_sram_we) mem_b[bus_b.o_sram_addr[7:0]] <= bus_b.o_sram_wdata;
  assign bus_a.i_sram_rdata = ovr_en ? ovr_val : mem_a[bus_a.o_sram_addr[7:0]];
  assign bus_b.i_sram_rdata = mem_b[bus_b.o_sram_addr[7:0]];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_a(input bit p, input logic cs, input logic we, input logic [AW-1:0] ad, input logic [7:0] d);
    if (p) begin
      bus_a.i_cs1 = cs; bus_a.i_we1 = we; bus_a.i_addr1 = ad; bus_a.i_wdata1 = d;
    end else begin
      bus_a.i_cs0 = cs; bus_a.i_we0 = we; bus_a.i_addr0 = ad; bus_a.i_wdata0 = d;
    end
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [15:0] addr;
    logic [7:0] wdata;
    bit         ovr;
    logic [7:0] ovr_val;
    int         exp_lat;
    int         exp_strb;
    logic [7:0] exp_rd;
  } vec_t;

  // Called at a negedge with the arbiter in IDLE; returns at the ack negedge.
  task automatic run_vec(input vec_t v, output int lat, output int strb, output int bad);
    lat = -1; strb = 0; bad = 0;
    ovr_en = v.ovr; ovr_val = v.ovr_val;
    set_a(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int t = 1; t <= 20 && lat < 0; t++) begin
      @(negedge clk);
      if (bus_a.o_sram_cs && bus_a.o_sram_addr == v.addr &&
          (v.we ? (bus_a.o_sram_we && !bus_a.o_sram_oe && bus_a.o_sram_wdata == v.wdata)
                : (bus_a.o_sram_oe && !bus_a.o_sram_we))) strb++;
      if (v.port ? bus_a.o_ack0 : bus_a.o_ack1) bad++;
      if (v.port ? bus_a.o_ack1 : bus_a.o_ack0) lat = t;
    end
    set_a(v.port, 1'b0, 1'b0, v.addr, v.wdata);
    ovr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t tbl[6];
  logic [7:0] ref_mem [256];
  bit         ref_ok  [256];

  initial begin
    int lat, strb, bad;
    int grants[$];
    int exp_g[4];
    int acks_b[$];
    int we_cnt, oe_cnt, a0, a1;
    bit pend[2];
    bit rwe[2];
    logic [15:0] rad[2];
    logic [7:0]  rdt[2];
    int e, free_at, ack_edge, win, m_last;
    bit g_we, rd_chk;
    logic [7:0] exp_rd;
    logic [1:0] exp_acks;

    tbl[0] = '{0, 1, 16'h1234, 8'hA5, 0, 8'h00, W_A+2, W_A+1, 8'h00};
    tbl[1] = '{1, 0, 16'h0010, 8'h00, 1, 8'h5C, W_A+2, W_A+1, 8'h5C};
    tbl[2] = '{1, 1, 16'h0003, 8'h3C, 0, 8'h00, W_A+2, W_A+1, 8'h5C};
    tbl[3] = '{0, 0, 16'h0003, 8'h00, 0, 8'h00, W_A+2, W_A+1, 8'h3C};
    tbl[4] = '{1, 0, 16'h1234, 8'h00, 0, 8'h00, W_A+2, W_A+1, 8'hA5};
    tbl[5] = '{0, 1, 16'h00FF, 8'h81, 0, 8'h00, W_A+2, W_A+1, 8'hA5};

    rst_n = 1'b0;
    set_a(0, 0, 0, '0, '0); set_a(1, 0, 0, '0, '0);
    bus_b.i_cs0 = 0; bus_b.i_we0 = 0; bus_b.i_addr0 = '0; bus_b.i_wdata0 = '0;
    bus_b.i_cs1 = 0; bus_b.i_we1 = 0; bus_b.i_addr1 = '0; bus_b.i_wdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {bus_a.o_sram_cs, bus_a.o_sram_we, bus_a.o_sram_oe, bus_a.o_ack0, bus_a.o_ack1}, 0);
    check("reset_data", {bus_a.o_rdata, bus_a.o_sram_addr, bus_a.o_sram_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], lat, strb, bad);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("vec%0d_strobe", i), strb, tbl[i].exp_strb);
      check($sformatf("vec%0d_other_ack", i), bad, 0);
      check($sformatf("vec%0d_rdata", i), bus_a.o_rdata, tbl[i].exp_rd);
      @(negedge clk);
    end
    check("hold_addr_wdata", {bus_a.o_sram_cs, bus_a.o_sram_addr, bus_a.o_sram_wdata}, {1'b0, 16'h00FF, 8'h81});

    // Contention: both ports keep read requests up for four accesses.
    set_a(0, 1, 0, 16'h0001, 8'h00);
    set_a(1, 1, 0, 16'h0002, 8'h00);
    for (int t = 0; t < 60 && grants.size() < 4; t++) begin
      @(negedge clk);
      check("cont_ack_excl", bus_a.o_ack0 & bus_a.o_ack1, 0);
      if (bus_a.o_ack0) grants.push_back(0);
      if (bus_a.o_ack1) grants.push_back(1);
    end
    set_a(0, 0, 0, '0, '0); set_a(1, 0, 0, '0, '0);
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check("cont_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_g[i]);
    @(negedge clk);

    // Reset in the second ACCESS cycle; held request re-runs after release.
    set_a(0, 1, 1, 16'h0055, 8'h77);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_strobes_drop", {bus_a.o_sram_cs, bus_a.o_sram_we, bus_a.o_sram_oe}, 0);
    @(negedge clk);
    check("rst_no_ack", {bus_a.o_ack1, bus_a.o_ack0}, 0);
    check("rst_rdata_clr", bus_a.o_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1; bad = 0;
    for (int t = 1; t <= 20 && lat < 0; t++) begin
      @(negedge clk);
      if (bus_a.o_ack1) bad++;
      if (bus_a.o_ack0) lat = t;
    end
    set_a(0, 0, 0, '0, '0);
    check("rst_reexec_lat", lat, W_A + 2);
    check("rst_reexec_addr", {bus_a.o_sram_addr, bus_a.o_sram_wdata}, {16'h0055, 8'h77});
    check("rst_reexec_other", bad, 0);
    @(negedge clk);

    // WAIT_CYCLES=0: write then read back on port 0, held cs between them.
    bus_b.i_cs0 = 1; bus_b.i_we0 = 1; bus_b.i_addr0 = 16'h0005; bus_b.i_wdata0 = 8'h9E;
    we_cnt = 0; oe_cnt = 0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (bus_b.o_sram_we) we_cnt++;
      if (bus_b.o_sram_oe) oe_cnt++;
      if (bus_b.o_ack0) begin
        acks_b.push_back(t);
        if (acks_b.size() == 1) bus_b.i_we0 = 0;
        else bus_b.i_cs0 = 0;
      end
    end
    bus_b.i_cs0 = 0;
    a0 = (acks_b.size() > 0) ? acks_b[0] : -1;
    a1 = (acks_b.size() > 1) ? acks_b[1] : -1;
    check("w0_ack_count", acks_b.size(), 2);
    check("w0_write_lat", a0, 2);
    check("w0_read_ack", a1, 5);
    check("w0_we_cycles", we_cnt, 1);
    check("w0_oe_cycles", oe_cnt, 1);
    check("w0_readback", bus_b.o_rdata, 8'h9E);

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) ref_ok[i] = 0;
    pend = '{0, 0};
    e = 0; free_at = 1; ack_edge = -1; win = 0; m_last = 1; rd_chk = 0; exp_rd = '0; g_we = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      e++;
      if (e >= free_at && (pend[0] || pend[1])) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
        win = (pend[0] && pend[1]) ? 1 - m_last : (pend[0] ? 0 : 1);
`else
        win = pend[0] ? 0 : 1;
`endif
        m_last   = win;
        ack_edge = e + W_A + 1;
        free_at  = e + W_A + 3;
        g_we     = rwe[win];
        if (g_we) begin
          ref_mem[rad[win][7:0]] = rdt[win];
          ref_ok[rad[win][7:0]]  = 1;
          rd_chk = 0;
        end else begin
          rd_chk = ref_ok[rad[win][7:0]];
          exp_rd = ref_mem[rad[win][7:0]];
        end
      end
      exp_acks = (e == ack_edge) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("rand_acks", {bus_a.o_ack1, bus_a.o_ack0}, exp_acks);
      check("rand_we_oe", bus_a.o_sram_we & bus_a.o_sram_oe, 0);
      if (e == ack_edge && rd_chk) check("rand_rdata", bus_a.o_rdata, exp_rd);
      if (e == ack_edge) pend[win] = 0;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 3) == 0) begin
          pend[p] = 1;
          rwe[p]  = 1'($urandom % 2);
          rad[p]  = 16'($urandom % 8);
          rdt[p]  = 8'($urandom);
        end
        set_a(p[0], pend[p], rwe[p], rad[p], rdt[p]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
